ahb_bus_arbiter: RTL
====================

Name: ahb_bus_arbiter

Overview:
- Round-robin arbiter and address/data multiplexer that shares the single AHB slave port of Bridge_Top between NUM_MASTERS AHB requesters.
- Sits between the requesters and Bridge_Top; drives the bridge's Haddr/Htrans/Hwrite/Hwdata/Hreadyin.
- Returns Hreadyout/Hrdata/Hresp to all masters.
- Enforces AHB address/data pipelining, handover only on ready, and a maximum burst length before forced re-arbitration.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, accepted beats per tenure before yielding if another master is requesting (>=1)

Ports:
- Hclk  in  1  clock, all logic on rising edge
- Hreset  in  1  synchronous active-high reset
- m_Hbusreq  in  NUM_MASTERS  bus request per master
- m_Haddr  in  NUM_MASTERS*ADDR_W  flattened addresses, master i at [i*ADDR_W +: ADDR_W]
- m_Htrans  in  NUM_MASTERS*2  flattened Htrans
- m_Hwrite  in  NUM_MASTERS  write flags
- m_Hwdata  in  NUM_MASTERS*DATA_W  flattened write data
- m_Hgrant  out  NUM_MASTERS  one-hot grant, registered
- Hmaster  out  $clog2(NUM_MASTERS)  current address-phase owner index
- m_Hready  out  1  broadcast ready (= s_Hreadyout)
- m_Hrdata  out  DATA_W  broadcast read data (= s_Hrdata)
- m_Hresp  out  2  broadcast response (= s_Hresp)
- s_Haddr  out  ADDR_W  to bridge Haddr
- s_Htrans  out  2  to bridge Htrans
- s_Hwrite  out  1  to bridge Hwrite
- s_Hwdata  out  DATA_W  to bridge Hwdata
- s_Hreadyin  out  1  to bridge Hreadyin (= s_Hreadyout)
- s_Hreadyout  in  1  from bridge Hreadyout
- s_Hrdata  in  DATA_W  from bridge Hrdata
- s_Hresp  in  2  from bridge Hresp

Behaviour:
- Reset values (registered):
  - m_Hgrant=0, Hmaster=0, state=IDLE, beat_cnt=0, last_owner=NUM_MASTERS-1
  - data-phase owner dmaster=0, dvalid=0
  - s_Htrans=2'b00 (IDLE)
- FSM states: IDLE, OWN.
  - IDLE: no grant; s_Htrans forced 00; s_Haddr/s_Hwrite = 0.
  - IDLE->OWN when any m_Hbusreq is set. Winner = first requester searching from last_owner+1 with wrap. Registered: grant is visible next cycle, beat_cnt=0.
  - OWN: s_Haddr/s_Htrans/s_Hwrite are combinationally muxed from master Hmaster.
- A beat is accepted when s_Htrans[1]=1 and s_Hreadyout=1. Each accepted beat increments beat_cnt.
- Re-arbitration happens only on a cycle with s_Hreadyout=1. Trigger is any of:
  - (a) owner's m_Hbusreq=0;
  - (b) owner's m_Htrans=00;
  - (c) beat_cnt reaches MAX_BURST with that cycle's beat and another master is requesting.
- On re-arbitration:
  - last_owner<=Hmaster.
  - If another requester exists, grant moves to the next one round-robin; state stays OWN; beat_cnt<=0.
  - If only the owner is still requesting after (c), the owner keeps the grant and beat_cnt<=0.
  - If no requester exists, go to IDLE and m_Hgrant<=0.
- The outgoing owner's address driven in the re-arbitration cycle is its final accepted beat. The new owner's first address phase is the next cycle and must be NONSEQ.
- When s_Hreadyout=0:
  - Grant, Hmaster and all registers hold, even if the owner deasserts m_Hbusreq.
  - The held address and control stay muxed from the same owner.
- Data phase:
  - On each s_Hreadyout=1 edge: dmaster<=Hmaster; dvalid<=(state==OWN and s_Htrans[1]).
  - s_Hwdata = m_Hwdata of dmaster when dvalid=1, else 0.
  - Data-phase ownership is independent of a grant change in the same cycle.
- Return path: m_Hready, m_Hrdata and m_Hresp are combinational broadcasts. Masters qualify them with their own data-phase ownership.
- Reset mid-transfer: all registers return to their reset values on the next edge. The in-flight beat is abandoned and no grant is issued during reset.
- Only one requester: that master is granted continuously. beat_cnt wraps to 0 at MAX_BURST with no handover.

Optional Feature:
- Macro: FIXED_PRIORITY_EN.
- Defined:
  - Winner is the lowest-index requesting master; last_owner is unused.
  - Trigger (c) yields only if a lower-index master is requesting. A higher-index owner is preempted at the MAX_BURST boundary; a lower-index owner keeps the grant.
- Undefined: round-robin exactly as described in Behaviour.

Test Plan:
- Reset held 3 cycles with all m_Hbusreq=4'b1111 -> m_Hgrant=0 and s_Htrans=00 throughout; first grant 4'b0001 appears one cycle after Hreset falls.
- Masters 0 and 2 request continuously with NONSEQ/SEQ bursts, s_Hreadyout=1, MAX_BURST=8 -> grant alternates 0001/0100 every 8 accepted beats; no beat is dropped or duplicated.
- Master 1 writes Haddr=32'h8000_0010, Hwdata=32'hA5A5_0001 while master 3 waits -> s_Hwdata=A5A5_0001 in the data phase following handover to master 3, even though the grant has already changed.
- s_Hreadyout held low 4 cycles while owner 0 drops m_Hbusreq and master 1 requests -> grant, Hmaster and s_Haddr are stable for all 4 cycles; handover occurs on the first ready=1 cycle.
- Hreset asserted mid-burst of master 2 at beat 5 -> next edge m_Hgrant=0, dvalid=0, s_Hwdata=0; after release, arbitration restarts from master 0.
- With FIXED_PRIORITY_EN defined, masters 0 and 3 request -> master 0 is granted and retains the grant indefinitely; master 3 is granted only after master 0 deasserts m_Hbusreq.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter and address/data mux sharing one bridge slave port among NUM_MASTERS requesters.
// Define FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 8
) (
  input  logic                             Hclk,
  input  logic                             Hreset,
  input  logic [NUM_MASTERS-1:0]           m_Hbusreq,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    m_Haddr,
  input  logic [NUM_MASTERS*2-1:0]         m_Htrans,
  input  logic [NUM_MASTERS-1:0]           m_Hwrite,
  input  logic [NUM_MASTERS*DATA_W-1:0]    m_Hwdata,
  output logic [NUM_MASTERS-1:0]           m_Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0]   Hmaster,
  output logic                             m_Hready,
  output logic [DATA_W-1:0]                m_Hrdata,
  output logic [1:0]                       m_Hresp,
  output logic [ADDR_W-1:0]                s_Haddr,
  output logic [1:0]                       s_Htrans,
  output logic                             s_Hwrite,
  output logic [DATA_W-1:0]                s_Hwdata,
  output logic                             s_Hreadyin,
  input  logic                             s_Hreadyout,
  input  logic [DATA_W-1:0]                s_Hrdata,
  input  logic [1:0]                       s_Hresp
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MW-1:0]          hmaster_q;
  logic [MW-1:0]          last_owner_q;
  logic [MW-1:0]          dmaster_q;
  logic                   dvalid_q;
  logic [CW-1:0]          beat_cnt_q;

  logic [ADDR_W-1:0]      addr_a  [NUM_MASTERS];
  logic [1:0]             trans_a [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_a [NUM_MASTERS];

  logic [1:0]             own_trans;
  logic                   own_req;
  logic [CW-1:0]          cnt_d;
  logic                   burst_done;
  logic                   others;
  logic                   rearb;
  logic                   win_found;
  logic [MW-1:0]          win_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      addr_a[i]  = m_Haddr[i*ADDR_W +: ADDR_W];
      trans_a[i] = m_Htrans[i*2 +: 2];
      wdata_a[i] = m_Hwdata[i*DATA_W +: DATA_W];
    end
  end

  assign own_trans  = trans_a[hmaster_q];
  assign own_req    = m_Hbusreq[hmaster_q];
  assign cnt_d      = beat_cnt_q + CW'(own_trans[1]);
  assign burst_done = own_trans[1] && (cnt_d == CW'(MAX_BURST));
  assign rearb      = !own_req || (own_trans == 2'b00) || (burst_done && others);

`ifdef FIXED_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    others    = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!win_found && m_Hbusreq[i]) begin
        win_found = 1'b1;
        win_idx   = MW'(i);
      end
      if (m_Hbusreq[i] && (i < 32'(hmaster_q))) others = 1'b1;
    end
  end
`else
  logic [MW-1:0]     base;
  int unsigned       k;

  // Search starts after the current owner in OWN, after the previous owner in IDLE.
  always_comb begin
    base      = (state_q == OWN) ? hmaster_q : last_owner_q;
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      k = (32'(base) + i) % NUM_MASTERS;
      if (!win_found && m_Hbusreq[k]) begin
        win_found = 1'b1;
        win_idx   = MW'(k);
      end
    end
    others = |(m_Hbusreq & ~(NUM_MASTERS'(1) << hmaster_q));
  end
`endif

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      hmaster_q    <= '0;
      last_owner_q <= MW'(NUM_MASTERS - 1);
      dmaster_q    <= '0;
      dvalid_q     <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      if (s_Hreadyout) begin
        dmaster_q <= hmaster_q;
        dvalid_q  <= (state_q == OWN) && own_trans[1];
      end
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q    <= OWN;
            hmaster_q  <= win_idx;
            grant_q    <= NUM_MASTERS'(1) << win_idx;
            beat_cnt_q <= '0;
          end
        end
        OWN: begin
          if (s_Hreadyout) begin
            if (rearb) begin
              last_owner_q <= hmaster_q;
              beat_cnt_q   <= '0;
              if (win_found) begin
                hmaster_q <= win_idx;
                grant_q   <= NUM_MASTERS'(1) << win_idx;
              end else begin
                state_q <= IDLE;
                grant_q <= '0;
              end
            end else begin
              beat_cnt_q <= burst_done ? '0 : cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_Hgrant   = grant_q;
  assign Hmaster    = hmaster_q;
  assign s_Haddr    = (state_q == OWN) ? addr_a[hmaster_q] : '0;
  assign s_Htrans   = (state_q == OWN) ? own_trans : 2'b00;
  assign s_Hwrite   = (state_q == OWN) ? m_Hwrite[hmaster_q] : 1'b0;
  assign s_Hwdata   = dvalid_q ? wdata_a[dmaster_q] : '0;
  assign s_Hreadyin = s_Hreadyout;
  assign m_Hready   = s_Hreadyout;
  assign m_Hrdata   = s_Hrdata;
  assign m_Hresp    = s_Hresp;

endmodule
